// File: rtl/sram_read_streamer.sv
// sram_read_streamer: turns a (base, count) read command into sequential SRAM
// reads and presents the returned words as a valid/ready stream with a
// last-beat marker.
//
// Handshake: a beat transfers on a rising edge where m_valid && m_ready.
// m_valid never depends on m_ready, and once m_valid is high m_data and
// m_last hold their values until the beat transfers.
//
// The SRAM returns data one cycle after a read is issued. A 2-entry FIFO
// catches that data. A read is only issued when the word it returns is
// guaranteed a free FIFO slot, so no beat is ever dropped.
module sram_read_streamer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_chip_en,
    output logic                  sram_ren,
    output logic [ADDR_WIDTH-1:0] sram_raddr,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         accepted;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  inflight;

    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  fifo_wp;
    logic                  fifo_rp;
    logic [1:0]            fifo_count;

    logic                  start_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [2:0]            occ;

    assign start_ok = (state == S_IDLE) && start;
    assign push     = inflight;
    assign pop      = (fifo_count != 2'd0) && m_ready;

    // Words already held or still on their way back from the SRAM.
    assign occ      = {1'b0, fifo_count} + {2'b00, inflight};

    // occ - pop < 2, written without subtraction so it cannot underflow.
    assign issue    = (state == S_RUN) && (issued < cnt_q) &&
                      (occ < (3'd2 + {2'b00, pop}));

    assign sram_ren     = issue;
    assign sram_chip_en = issue;
    assign sram_raddr   = rd_ptr;

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = fifo_mem[fifo_rp];
    assign m_last  = m_valid && (accepted == (cnt_q - CW'(1)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DRAIN looks at this cycle's pop so done follows the
    // last accepted beat with no extra cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (count != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (issued == cnt_q) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((accepted + CW'(pop)) == cnt_q) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Command latch, issue/accept counters and the wrapping read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            issued   <= '0;
            accepted <= '0;
            rd_ptr   <= '0;
        end else if (start_ok) begin
            cnt_q    <= count;
            issued   <= '0;
            accepted <= '0;
            rd_ptr   <= base_addr;
        end else begin
            if (issue) begin
                issued <= issued + CW'(1);
                if (rd_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                    rd_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                end
            end
            if (pop) begin
                accepted <= accepted + CW'(1);
            end
        end
    end

    // In-flight flag: a read issued on this edge returns data next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    // 2-entry FIFO; a simultaneous push and pop while full keeps it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wp] <= sram_dout;
                fifo_wp           <= ~fifo_wp;
            end
            if (pop) begin
                fifo_rp <= ~fifo_rp;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sram_read_streamer.sv
// Directed testbench for sram_read_streamer with a registered-read SRAM model.
module tb_sram_read_streamer;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          sram_chip_en;
    logic          sram_ren;
    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    logic [DW-1:0] mem [16];

    // scoreboard
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_iss   = 0;
    int n_acc   = 0;
    int cmd_issues = 0;
    int cmd_beats  = 0;
    int first_cyc  = 0;
    int last_cyc   = 0;
    int ready_mode = 0;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    sram_read_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .sram_chip_en (sram_chip_en),
        .sram_ren     (sram_ren),
        .sram_raddr   (sram_raddr),
        .sram_dout    (sram_dout),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read, data valid the cycle after ren
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA0 + i;
        sram_dout = '0;
    end
    always @(posedge clk) begin
        if (sram_ren) sram_dout <= mem[sram_raddr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // consumer ready driver: mode 1 plays 1,0,0,1,0,1 repeatedly
    initial begin
        logic [5:0] pat;
        int idx;
        pat = 6'b101001;
        idx = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (ready_mode == 1) ? pat[idx] : 1'b1;
            idx = (idx == 5) ? 0 : idx + 1;
        end
    end

    // monitor: sampled on the falling edge, predicts the next rising edge
    always @(negedge clk) begin
        int  occ;
        logic pop;
        cyc++;
        if (!rst_n) begin
            n_iss = 0;
            n_acc = 0;
            prev_stall = 1'b0;
        end else begin
            if (start && !busy) begin
                cmd_issues = 0;
                cmd_beats  = 0;
            end
            occ = n_iss - n_acc;
            pop = m_valid && m_ready;
            if (sram_ren) begin
                check("cen", sram_chip_en, 1);
                check("occ_rule", ((occ - int'(pop)) < 2), 1);
                if (exp_addr_q.size() == 0) check("extra_read", 1, 0);
                else check("raddr", sram_raddr, exp_addr_q.pop_front());
                n_iss++;
                cmd_issues++;
            end
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
                check("stall_last", m_last, prev_last);
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check("data", m_data, exp_q.pop_front());
                    check("last", m_last, exp_last_q.pop_front());
                end
                if (cmd_beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_acc++;
                cmd_beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // driver tasks
    task automatic expect_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        exp_addr_q.push_back(a);
        exp_q.push_back(d);
        exp_last_q.push_back(l);
    endtask

    task automatic expect_cmd(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            expect_beat(AW'((b + i) % 16), 32'hA0 + ((b + i) % 16), (i == n - 1));
        end
    endtask

    task automatic do_start(input int b, input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = AW'(b);
        count = (AW + 1)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // done must appear in the cycle right after the edge taking the last beat
    task automatic wait_done(input logic chk_lat);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (done) break;
        end
        check("done_seen", done, 1);
        if (chk_lat) check("done_latency", cyc, last_cyc);
        @(posedge clk);
        #2;
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ren", sram_ren, 0);
        check("rst_cen", sram_chip_en, 0);
        check("rst_raddr", sram_raddr, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        rst_n = 1'b1;

        // basic read, base 3 count 4
        expect_beat(4'd3, 32'hA3, 1'b0);
        expect_beat(4'd4, 32'hA4, 1'b0);
        expect_beat(4'd5, 32'hA5, 1'b0);
        expect_beat(4'd6, 32'hA6, 1'b1);
        do_start(3, 4);
        check("lat_busy", busy, 1);
        check("lat_ren", sram_ren, 1);
        check("lat_raddr", sram_raddr, 3);
        check("lat_valid0", m_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid1", m_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid2", m_valid, 1);
        check("lat_data2", m_data, 32'hA3);
        wait_done(1'b1);
        check("basic_beats", cmd_beats, 4);
        check("basic_tput", last_cyc - first_cyc, 3);

        // wrap-around, base 14 count 4
        expect_beat(4'd14, 32'hAE, 1'b0);
        expect_beat(4'd15, 32'hAF, 1'b0);
        expect_beat(4'd0,  32'hA0, 1'b0);
        expect_beat(4'd1,  32'hA1, 1'b1);
        do_start(14, 4);
        wait_done(1'b1);
        check("wrap_beats", cmd_beats, 4);

        // backpressure, base 7 count 6
        ready_mode = 1;
        expect_cmd(7, 6);
        do_start(7, 6);
        wait_done(1'b1);
        check("bp_beats", cmd_beats, 6);
        ready_mode = 0;

        // zero length
        do_start(5, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 1);
        @(posedge clk);
        #1;
        check("zero_done_off", done, 0);
        check("zero_idle", busy, 0);
        check("zero_issues", cmd_issues, 0);
        check("zero_beats", cmd_beats, 0);

        // full length, base 0 count 16
        expect_cmd(0, 16);
        do_start(0, 16);
        wait_done(1'b1);
        check("full_beats", cmd_beats, 16);
        check("full_tput", last_cyc - first_cyc, 15);

        // start while busy is ignored
        expect_cmd(3, 4);
        do_start(3, 4);
        start = 1'b1;
        base_addr = 4'd0;
        count = 5'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b1);
        check("busy_start_beats", cmd_beats, 4);
        check("busy_start_issues", cmd_issues, 4);

        // reset mid-operation after 2 beats
        expect_cmd(0, 8);
        do_start(0, 8);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (cmd_beats >= 2) break;
        end
        check("mid_two_beats", cmd_beats, 2);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_ren", sram_ren, 0);
        check("mid_raddr", sram_raddr, 0);
        check("mid_valid", m_valid, 0);
        check("mid_last", m_last, 0);
        check("mid_data", m_data, 0);
        check("mid_done", done, 0);
        exp_q.delete();
        exp_last_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_cmd(5, 3);
        do_start(5, 3);
        wait_done(1'b1);
        check("post_rst_beats", cmd_beats, 3);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_read_streamer.md
Name: sram_read_streamer

Overview:
- Downstream read-side stage for the SRAM buffer. Takes a (base, count) read command and issues sequential reads on the SRAM read port.
- Absorbs the SRAM's 1-cycle registered read latency and presents the data as a valid/ready stream with last-beat marking.
- A 2-entry skid FIFO guarantees no beat is lost under backpressure, while sustaining 1 beat/cycle when the consumer is always ready.

Parameters:
- ADDR_WIDTH, 4, SRAM address width.
- DATA_WIDTH, 32, SRAM word / stream data width.
- DEPTH, 16, number of SRAM words; address wrap point.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle command strobe, sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first read address, captured with start.
- count  input  ADDR_WIDTH+1  number of words to read (0..DEPTH), captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  1-cycle pulse after the final beat is accepted.
- sram_chip_en  output  1  SRAM chip enable; equals sram_ren.
- sram_ren  output  1  SRAM read enable.
- sram_raddr  output  ADDR_WIDTH  SRAM read address.
- sram_dout  input  DATA_WIDTH  SRAM read data, valid the cycle after the ren edge.
- m_valid  output  1  stream beat valid.
- m_ready  input  1  consumer ready.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  marks the final beat of the command.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset clears everything: state=IDLE, busy=0, done=0, sram_ren=0, sram_chip_en=0, sram_raddr=0, m_valid=0, m_last=0, m_data=0, FIFO empty, in-flight flag cleared, all counters 0.
  - Reset asserted mid-command aborts the command immediately. Any in-flight SRAM data is discarded.
- FSM states:
  - IDLE: start=1 with count>0 -> RUN; latch base_addr/count; issued=0, accepted=0. start=1 with count=0 -> DONE; no SRAM access.
  - RUN: issue reads; when issued==count -> DRAIN.
  - DRAIN: wait until accepted==count -> DONE.
  - DONE: done=1 for exactly 1 cycle, then -> IDLE.
  - busy=1 in RUN, DRAIN and DONE. start is ignored while busy.
- Read issue (combinational from registered state):
  - sram_ren = (state==RUN) && (issued<count) && (occ - pop < 2), where occ = fifo_count + inflight and pop = m_valid && m_ready.
  - sram_raddr = rd_ptr. rd_ptr loads base_addr on start and increments on each issue.
  - rd_ptr wraps from DEPTH-1 to 0, also for non-power-of-2 DEPTH.
- Read return:
  - inflight is set on each issue edge. The next cycle, sram_dout is pushed into the FIFO at the following edge.
  - The FIFO never overflows, by the occupancy rule above.
- Stream output:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_data and m_last must stay stable while m_valid && !m_ready.
  - m_last = 1 on the beat where accepted == count-1.
  - Simultaneous push and pop with FIFO count 2 is legal and keeps the count at 2.
- Latency and throughput:
  - Accepted start at edge E0 -> sram_ren high in the cycle after E0 -> FIFO push at E2 -> m_valid high after E2 (2 cycles).
  - With m_ready held at 1, one beat per cycle and no bubbles.
  - done is high in the cycle after the edge that accepts the last beat.
- Arithmetic:
  - issued and accepted are ADDR_WIDTH+1 bits wide, so count=DEPTH is legal.
  - count>DEPTH rereads wrapped addresses and is legal.

Test Plan:
- Basic read: preload mem[i]=0xA0+i; start, base=3, count=4, m_ready=1 -> beats A3,A4,A5,A6; m_last on A6; first m_valid 2 cycles after start; done 1 cycle after A6 accepted.
- Wrap-around: base=14, count=4 -> sram_raddr sequence 14,15,0,1; data in that order.
- Backpressure: count=6; m_ready toggles 1,0,0,1,0,1... -> all 6 beats in order, no loss, no duplicates; m_data stable during stalls; sram_ren never high when occ - pop ≥ 2.
- Zero/full length: count=0 -> done pulses with no sram_ren and no m_valid. count=16 -> 16 beats, m_last on the 16th.
- Start while busy: second start during RUN -> ignored. Output matches the first command only.
- Reset mid-operation: rst_n low after 2 beats -> all outputs 0 immediately. A new command after release streams correctly, with no stale beats.
